// File: rtl/fv_core_si_instr_driver.sv
// Feeds NOPs to the core fetch port, launches one symbolic instruction at CAPTURE_CYCLE, then drains and parks.
// instruction/si_launch/si_accepted are combinational; other outputs registered. Optional filter: FV_SI_LEGAL_OPCODE_EN.
module fv_core_si_instr_driver #(
  parameter int                     INSTR_WIDTH   = 32,
  parameter int                     ADDR_WIDTH    = 32,
  parameter int                     CNT_WIDTH     = 10,
  parameter int                     CAPTURE_CYCLE = 20,
  parameter int                     MAX_HOLD      = 8,
  parameter int                     DRAIN_CYCLES  = 16,
  parameter logic [INSTR_WIDTH-1:0] NOP           = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] free_instr,
  input  logic                   instr_ready,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instruction_valid,
  output logic [CNT_WIDTH-1:0]   clock_counter,
  output logic                   si_launch,
  output logic                   si_accepted,
  output logic [ADDR_WIDTH-1:0]  si_pc,
  output logic                   done,
  output logic                   hold_timeout,
  output logic                   illegal_filtered
);

  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CAP_VAL    = CNT_WIDTH'(CAPTURE_CYCLE);
  localparam logic [HCW-1:0]       HOLD_LAST  = HCW'(MAX_HOLD - 1);
  localparam logic [DCW-1:0]       DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {FILL, HOLD, DRAIN, DONE} state_t;

  state_t                 state;
  logic [HCW-1:0]         hold_cnt;
  logic [DCW-1:0]         drain_cnt;
  logic [INSTR_WIDTH-1:0] si_reg;
  logic [INSTR_WIDTH-1:0] sel_instr;
  logic                   launch_cyc;

`ifdef FV_SI_LEGAL_OPCODE_EN
  logic sel_illegal;

  always_comb begin
    sel_illegal = 1'b1;
    case (free_instr[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: sel_illegal = 1'b0;
`ifdef FV_INCLUDE_RV64
      7'b0011011, 7'b0111011: sel_illegal = 1'b0;
`endif
      default: sel_illegal = 1'b1;
    endcase
    sel_instr = sel_illegal ? NOP : free_instr;
  end
`else
  assign sel_instr        = free_instr;
  assign illegal_filtered = 1'b0;
`endif

  // The saturated counter can never match CAP_VAL, so this fires once per reset.
  assign launch_cyc  = (state == FILL) && (clock_counter == CAP_VAL);
  assign si_launch   = launch_cyc;
  assign si_accepted = instr_ready && (launch_cyc || (state == HOLD));

  always_comb begin
    instruction = NOP;
    if (launch_cyc)
      instruction = sel_instr;
    else if (state == HOLD)
      instruction = si_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= FILL;
      clock_counter     <= '0;
      hold_cnt          <= '0;
      drain_cnt         <= '0;
      si_reg            <= NOP;
      si_pc             <= '0;
      instruction_valid <= 1'b1;
      done              <= 1'b0;
      hold_timeout      <= 1'b0;
`ifdef FV_SI_LEGAL_OPCODE_EN
      illegal_filtered  <= 1'b0;
`endif
    end else begin
      if (clock_counter != CNT_MAX)
        clock_counter <= clock_counter + 1'b1;
      if (si_accepted)
        si_pc <= fetch_addr;
      case (state)
        FILL: begin
          if (launch_cyc) begin
            si_reg <= sel_instr;
            state  <= instr_ready ? DRAIN : HOLD;
`ifdef FV_SI_LEGAL_OPCODE_EN
            if (sel_illegal)
              illegal_filtered <= 1'b1;
`endif
          end
        end
        HOLD: begin
          // Acceptance takes priority over the hold limit.
          if (instr_ready) begin
            state <= DRAIN;
          end else if (hold_cnt == HOLD_LAST) begin
            state             <= DONE;
            hold_timeout      <= 1'b1;
            instruction_valid <= 1'b0;
            done              <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state             <= DONE;
            instruction_valid <= 1'b0;
            done              <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE:    state <= DONE;
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fv_core_si_instr_driver.sv
// Directed bench for fv_core_si_instr_driver: happy path, stall, timeout, saturation, mid-sequence reset, opcode filter.
module tb_fv_core_si_instr_driver;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h0020_8133;
  localparam logic [31:0] BAD = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] free_instr = '0;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic [9:0]  clock_counter;
  logic        si_launch;
  logic        si_accepted;
  logic [31:0] si_pc;
  logic        done;
  logic        hold_timeout;
  logic        illegal_filtered;

  int n_cmp = 0;
  int n_bad = 0;

  fv_core_si_instr_driver dut (
    .clk               (clk),
    .reset             (reset),
    .free_instr        (free_instr),
    .instr_ready       (instr_ready),
    .fetch_addr        (fetch_addr),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .clock_counter     (clock_counter),
    .si_launch         (si_launch),
    .si_accepted       (si_accepted),
    .si_pc             (si_pc),
    .done              (done),
    .hold_timeout      (hold_timeout),
    .illegal_filtered  (illegal_filtered)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    instr_ready = 1'b1;
    do_reset(2);
    #1;
    n_cmp++; if (instruction !== NOP) begin n_bad++; $display("FAIL reset_instr got %h exp %h", instruction, NOP); end
    n_cmp++; if (instruction_valid !== 1'b1) begin n_bad++; $display("FAIL reset_valid got %b exp 1", instruction_valid); end
    n_cmp++; if (clock_counter !== 10'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", clock_counter); end
    n_cmp++; if ({si_launch, si_accepted, done, hold_timeout, illegal_filtered} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got %b exp 00000", {si_launch, si_accepted, done, hold_timeout, illegal_filtered}); end
    n_cmp++; if (si_pc !== 32'h0) begin n_bad++; $display("FAIL reset_si_pc got %h exp 0", si_pc); end
  endtask

  task automatic test_happy();
    logic [31:0] exp_i;
    logic [31:0] exp_pc;
    do_reset(2);
    for (int c = 0; c <= 40; c++) begin
      instr_ready = 1'b1;
      fetch_addr  = 32'h8000_0000 + 32'(c * 4);
      free_instr  = (c == 20) ? ADD : $urandom;
      #1;
      exp_i  = (c == 20) ? ADD : NOP;
      exp_pc = (c > 20) ? 32'h8000_0050 : 32'h0;
      n_cmp++; if (instruction !== exp_i) begin n_bad++; $display("FAIL happy_instr c=%0d got %h exp %h", c, instruction, exp_i); end
      n_cmp++; if (clock_counter !== 10'(c)) begin n_bad++; $display("FAIL happy_cnt c=%0d got %0d exp %0d", c, clock_counter, c); end
      n_cmp++; if (si_launch !== (c == 20)) begin n_bad++; $display("FAIL happy_launch c=%0d got %b", c, si_launch); end
      n_cmp++; if (si_accepted !== (c == 20)) begin n_bad++; $display("FAIL happy_accept c=%0d got %b", c, si_accepted); end
      n_cmp++; if (done !== (c >= 37)) begin n_bad++; $display("FAIL happy_done c=%0d got %b exp %b", c, done, c >= 37); end
      n_cmp++; if (instruction_valid !== (c < 37)) begin n_bad++; $display("FAIL happy_valid c=%0d got %b exp %b", c, instruction_valid, c < 37); end
      n_cmp++; if (si_pc !== exp_pc) begin n_bad++; $display("FAIL happy_si_pc c=%0d got %h exp %h", c, si_pc, exp_pc); end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_i;
    do_reset(2);
    for (int c = 0; c <= 42; c++) begin
      instr_ready = !(c >= 20 && c <= 22);
      fetch_addr  = 32'h0000_1000 + 32'(c * 4);
      free_instr  = (c == 20) ? ADD : $urandom;
      #1;
      exp_i = (c >= 20 && c <= 23) ? ADD : NOP;
      n_cmp++; if (instruction !== exp_i) begin n_bad++; $display("FAIL stall_instr c=%0d got %h exp %h", c, instruction, exp_i); end
      n_cmp++; if (si_launch !== (c == 20)) begin n_bad++; $display("FAIL stall_launch c=%0d got %b", c, si_launch); end
      n_cmp++; if (si_accepted !== (c == 23)) begin n_bad++; $display("FAIL stall_accept c=%0d got %b", c, si_accepted); end
      n_cmp++; if (done !== (c >= 40)) begin n_bad++; $display("FAIL stall_done c=%0d got %b exp %b", c, done, c >= 40); end
      n_cmp++; if (hold_timeout !== 1'b0) begin n_bad++; $display("FAIL stall_timeout c=%0d got %b exp 0", c, hold_timeout); end
      if (c == 24) begin
        n_cmp++; if (si_pc !== 32'h0000_105C) begin n_bad++; $display("FAIL stall_si_pc got %h exp 0000105c", si_pc); end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [31:0] exp_i;
    do_reset(2);
    for (int c = 0; c <= 35; c++) begin
      instr_ready = (c < 20);
      free_instr  = (c == 20) ? ADD : $urandom;
      #1;
      exp_i = (c >= 20 && c <= 28) ? ADD : NOP;
      n_cmp++; if (instruction !== exp_i) begin n_bad++; $display("FAIL tmo_instr c=%0d got %h exp %h", c, instruction, exp_i); end
      n_cmp++; if (hold_timeout !== (c >= 29)) begin n_bad++; $display("FAIL tmo_flag c=%0d got %b exp %b", c, hold_timeout, c >= 29); end
      n_cmp++; if (done !== (c >= 29)) begin n_bad++; $display("FAIL tmo_done c=%0d got %b exp %b", c, done, c >= 29); end
      n_cmp++; if (instruction_valid !== (c < 29)) begin n_bad++; $display("FAIL tmo_valid c=%0d got %b exp %b", c, instruction_valid, c < 29); end
      n_cmp++; if (si_accepted !== 1'b0) begin n_bad++; $display("FAIL tmo_accept c=%0d got %b exp 0", c, si_accepted); end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (hold_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_clear got %b exp 0", hold_timeout); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL tmo_done_clear got %b exp 0", done); end
  endtask

  task automatic test_mid_reset();
    do_reset(2);
    for (int c = 0; c < 25; c++) begin
      instr_ready = 1'b1;
      fetch_addr  = 32'hA000_0000 + 32'(c);
      free_instr  = ADD;
      tick();
    end
    n_cmp++; if (si_pc !== 32'hA000_0014) begin n_bad++; $display("FAIL mid_pre_si_pc got %h exp a0000014", si_pc); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (clock_counter !== 10'd0) begin n_bad++; $display("FAIL mid_cnt got %0d exp 0", clock_counter); end
    n_cmp++; if (si_pc !== 32'h0) begin n_bad++; $display("FAIL mid_si_pc got %h exp 0", si_pc); end
    n_cmp++; if ({instruction_valid, done, hold_timeout} !== 3'b100) begin
      n_bad++; $display("FAIL mid_flags got %b exp 100", {instruction_valid, done, hold_timeout}); end
    for (int c = 0; c <= 37; c++) begin
      instr_ready = 1'b1;
      free_instr  = (c == 20) ? ADD : $urandom;
      #1;
      n_cmp++; if (si_launch !== (c == 20)) begin n_bad++; $display("FAIL mid_relaunch c=%0d got %b", c, si_launch); end
      n_cmp++; if (done !== (c >= 37)) begin n_bad++; $display("FAIL mid_done c=%0d got %b exp %b", c, done, c >= 37); end
      tick();
    end
  endtask

  task automatic test_saturation();
    logic [9:0] exp_c;
    do_reset(1);
    for (int c = 0; c <= 1030; c++) begin
      instr_ready = 1'b1;
      free_instr  = (c == 20) ? ADD : $urandom;
      #1;
      exp_c = (c > 1023) ? 10'd1023 : 10'(c);
      n_cmp++; if (clock_counter !== exp_c) begin n_bad++; $display("FAIL sat_cnt c=%0d got %0d exp %0d", c, clock_counter, exp_c); end
      n_cmp++; if (si_launch !== (c == 20)) begin n_bad++; $display("FAIL sat_launch c=%0d got %b", c, si_launch); end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [31:0] exp_i;
    logic        exp_f;
    do_reset(2);
    for (int c = 0; c <= 24; c++) begin
      instr_ready = 1'b1;
      free_instr  = (c == 20) ? BAD : NOP;
      #1;
`ifdef FV_SI_LEGAL_OPCODE_EN
      exp_i = NOP;
      exp_f = (c >= 21);
`else
      exp_i = (c == 20) ? BAD : NOP;
      exp_f = 1'b0;
`endif
      n_cmp++; if (instruction !== exp_i) begin n_bad++; $display("FAIL illegal_instr c=%0d got %h exp %h", c, instruction, exp_i); end
      n_cmp++; if (illegal_filtered !== exp_f) begin n_bad++; $display("FAIL illegal_flag c=%0d got %b exp %b", c, illegal_filtered, exp_f); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_stall();
    test_timeout();
    test_mid_reset();
    test_illegal();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
